voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Scheduler that shares a fixed pool of synthesis voices between incoming MIDI note events.
- Sits between the MIDI decoder output (and next to the parameter-control block) and the per-voice oscillator/envelope datapath.
- On each decoded NOTE_ON it assigns a voice: retrigger, then free, then optionally steal the oldest. On NOTE_OFF it releases the matching voice.
- Per-voice state is exposed as flat registered vectors with a per-voice change strobe.

Parameters:
VOICES, 8, number of voices in the pool (2..16)
AGE_W, 4, width of each per-voice saturating age counter

Ports:
clock_50_000_000  in  1  system clock
reset  in  1  asynchronous, active-high reset
msg_valid  in  1  decoded message present
msg_ready  out  1  allocator can accept; equals (state==IDLE)
msg_status  in  4  status nibble; 4'b1001 NOTE_ON, 4'b1000 NOTE_OFF
msg_note  in  7  note number
msg_velocity  in  7  velocity
voice_active  out  VOICES  voice i holds a note
voice_note  out  7*VOICES  note of voice i at bits [7i+6:7i]
voice_velocity  out  7*VOICES  velocity of voice i at bits [7i+6:7i]
voice_change  out  VOICES  one-cycle strobe: voice i was written this cycle
dropped  out  1  one-cycle strobe: NOTE_ON discarded, pool full

Behaviour:
- Clock and reset: one clock, clock_50_000_000. Reset is asynchronous and active-high.
- Reset values: all outputs 0 except msg_ready=1; all ages 0; state IDLE. Reset mid-scan aborts the operation with no voice update.
- Handshake: a message transfers on an edge where msg_valid && msg_ready. The message fields are latched at that edge.
- Unknown messages: any status other than NOTE_ON/NOTE_OFF is consumed and ignored. State stays IDLE, msg_ready stays 1.
- Velocity-0 notes: NOTE_ON with velocity 0 is treated as NOTE_OFF.
- FSM states: IDLE -> SCAN (on accepting a note message) -> COMMIT -> IDLE.
- SCAN (exactly VOICES cycles): examines voice idx = 0..VOICES-1, one per cycle, and records:
  - match = first active voice with note == latched note;
  - free = first inactive voice;
  - oldest = active voice with the largest age; ties go to the lowest index.
- COMMIT (one cycle), NOTE_ON:
  - target = match if found, else free if found, else oldest (steal; see the optional feature).
  - Writes active=1, note, velocity for the target, sets its age to 0, and pulses voice_change[target].
  - Every other active voice increments its age, saturating at 2^AGE_W-1. Inactive voices keep age 0.
- COMMIT (one cycle), NOTE_OFF:
  - With a match: active=0, velocity=0, note retained, age=0, pulse voice_change[match].
  - With no match: no change, no strobe.
- Latency: outputs and strobes update on the edge VOICES+1 edges after the accepting edge. msg_ready is low for VOICES+1 cycles, i.e. 9 with the defaults.
- Upstream holding: msg_valid may be held high across busy cycles. The message is taken on the first edge where msg_ready=1.
- Strobe exclusivity: at most one voice_change bit is set per cycle. dropped and voice_change are never both high.

Optional Feature:
VOICE_ALLOCATOR_STEAL_EN
- Defined: NOTE_ON with no match and no free voice steals the oldest voice. That voice is overwritten and voice_change pulses for it; dropped stays 0.
- Undefined: such a NOTE_ON changes no voice state and no ages. dropped pulses for one cycle in COMMIT.

Test Plan:
- Reset, then NOTE_ON note 60 vel 100 -> 9 edges later: voice_active=8'h01, voice_note[6:0]=60, voice_velocity[6:0]=100, voice_change=8'h01 for one cycle.
- NOTE_ON notes 60..67 in order, then NOTE_OFF 63 -> voice_active goes to 8'hFF, then 8'hF7; voice_change=8'h08; voice_note[27:21] stays 63.
- With all 8 voices held, NOTE_ON 70:
  - with STEAL_EN: voice 0 (oldest, age 7) gets note 70, voice_change=8'h01, dropped=0;
  - without STEAL_EN: dropped=1 for one cycle, voices unchanged.
- NOTE_ON 60 vel 100, then NOTE_ON 60 vel 20 -> still only voice 0 active, velocity becomes 20, voice_change=8'h01.
- Control-change 0xB0 with msg_valid high -> msg_ready stays 1, no strobes. NOTE_ON 50 vel 0 with no voice holding 50 -> no change, no strobe.
- Assert reset during SCAN of a NOTE_ON -> all outputs 0, msg_ready=1 immediately. No voice_change after reset deasserts.

Source files
------------

// File: rtl/voice_allocator.sv
// Voice allocator: NOTE_ON takes a retriggered, free or (with VOICE_ALLOCATOR_STEAL_EN) oldest voice; NOTE_OFF releases.
// Each note message occupies VOICES scan cycles plus one commit cycle; msg_ready is low throughout.
module voice_allocator #(
  parameter int VOICES = 8,
  parameter int AGE_W  = 4
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [3:0]            msg_status,
  input  logic [6:0]            msg_note,
  input  logic [6:0]            msg_velocity,
  output logic [VOICES-1:0]     voice_active,
  output logic [7*VOICES-1:0]   voice_note,
  output logic [7*VOICES-1:0]   voice_velocity,
  output logic [VOICES-1:0]     voice_change,
  output logic                  dropped
);

  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [3:0]       ST_NOTE_ON  = 4'b1001;
  localparam logic [3:0]       ST_NOTE_OFF = 4'b1000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [6:0]                    lat_note_q, lat_note_d;
  logic [6:0]                    lat_vel_q, lat_vel_d;
  logic                          lat_on_q, lat_on_d;

  logic                          match_found_q, match_found_d;
  logic [IW-1:0]                 match_idx_q, match_idx_d;
  logic                          free_found_q, free_found_d;
  logic [IW-1:0]                 free_idx_q, free_idx_d;
  logic                          old_found_q, old_found_d;
  logic [IW-1:0]                 old_idx_q, old_idx_d;
  logic [AGE_W-1:0]              old_age_q, old_age_d;

  logic [VOICES-1:0]             active_q, active_d;
  logic [VOICES-1:0][6:0]        note_q, note_d;
  logic [VOICES-1:0][6:0]        vel_q, vel_d;
  logic [VOICES-1:0][AGE_W-1:0]  age_q, age_d;
  logic [VOICES-1:0]             change_q, change_d;
  logic                          dropped_q, dropped_d;

  logic                          do_write;
  logic [IW-1:0]                 target;
  logic                          cur_active;

  assign msg_ready      = (state_q == S_IDLE);
  assign voice_active   = active_q;
  assign voice_note     = note_q;
  assign voice_velocity = vel_q;
  assign voice_change   = change_q;
  assign dropped        = dropped_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    lat_note_d    = lat_note_q;
    lat_vel_d     = lat_vel_q;
    lat_on_d      = lat_on_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    active_d      = active_q;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    change_d      = '0;
    dropped_d     = 1'b0;
    do_write      = 1'b0;
    target        = '0;
    cur_active    = active_q[idx_q];

    case (state_q)
      S_IDLE: begin
        // Non-note messages are accepted here too, simply by never leaving IDLE.
        if (msg_valid && (msg_status == ST_NOTE_ON || msg_status == ST_NOTE_OFF)) begin
          lat_note_d    = msg_note;
          lat_vel_d     = msg_velocity;
          lat_on_d      = (msg_status == ST_NOTE_ON) && (msg_velocity != 7'd0);
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          idx_d         = '0;
          state_d       = S_SCAN;
        end
      end

      S_SCAN: begin
        if (cur_active && !match_found_q && note_q[idx_q] == lat_note_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!cur_active && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strictly-greater keeps the lowest index on age ties.
        if (cur_active && (!old_found_q || age_q[idx_q] > old_age_q)) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = age_q[idx_q];
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        if (lat_on_q) begin
          if (match_found_q) begin
            do_write = 1'b1;
            target   = match_idx_q;
          end else if (free_found_q) begin
            do_write = 1'b1;
            target   = free_idx_q;
          end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
            do_write = old_found_q;
            target   = old_idx_q;
`else
            dropped_d = 1'b1;
`endif
          end
          if (do_write) begin
            for (int i = 0; i < VOICES; i++) begin
              if (IW'(i) == target) begin
                active_d[i] = 1'b1;
                note_d[i]   = lat_note_q;
                vel_d[i]    = lat_vel_q;
                age_d[i]    = '0;
                change_d[i] = 1'b1;
              end else if (active_q[i] && age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
          end
        end else if (match_found_q) begin
          for (int i = 0; i < VOICES; i++) begin
            if (IW'(i) == match_idx_q) begin
              active_d[i] = 1'b0;
              vel_d[i]    = '0;
              age_d[i]    = '0;
              change_d[i] = 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      lat_note_q    <= '0;
      lat_vel_q     <= '0;
      lat_on_q      <= 1'b0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      active_q      <= '0;
      note_q        <= '0;
      vel_q         <= '0;
      age_q         <= '0;
      change_q      <= '0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lat_note_q    <= lat_note_d;
      lat_vel_q     <= lat_vel_d;
      lat_on_q      <= lat_on_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      active_q      <= active_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
      change_q      <= change_d;
      dropped_q     <= dropped_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed and randomized note traffic for voice_allocator, checked against an array-based pool model.
module tb_voice_allocator;
  localparam int VOICES  = 8;
  localparam int AGE_W   = 4;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 msg_valid;
  logic                 msg_ready;
  logic [3:0]           msg_status;
  logic [6:0]           msg_note;
  logic [6:0]           msg_velocity;
  logic [VOICES-1:0]    voice_active;
  logic [7*VOICES-1:0]  voice_note;
  logic [7*VOICES-1:0]  voice_velocity;
  logic [VOICES-1:0]    voice_change;
  logic                 dropped;

  int n_cmp = 0;
  int n_err = 0;

  int m_act  [VOICES];
  int m_note [VOICES];
  int m_vel  [VOICES];
  int m_age  [VOICES];

  voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
    .clock_50_000_000(clk),
    .reset(reset),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_status(msg_status),
    .msg_note(msg_note),
    .msg_velocity(msg_velocity),
    .voice_active(voice_active),
    .voice_note(voice_note),
    .voice_velocity(voice_velocity),
    .voice_change(voice_change),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
  endtask

  // Pool rules: retrigger first, then first free voice, then oldest (lowest index on ties) or drop.
  task automatic model_apply(input int st, input int n, input int v,
                             output logic [VOICES-1:0] chg, output logic drop, output bit is_note);
    int t;
    bit on;
    chg = '0; drop = 1'b0;
    is_note = (st == 9) || (st == 8);
    if (!is_note) return;
    on = (st == 9) && (v != 0);
    t = -1;
    for (int i = 0; i < VOICES; i++) if (t < 0 && m_act[i] != 0 && m_note[i] == n) t = i;
    if (on) begin
      for (int i = 0; i < VOICES; i++) if (t < 0 && m_act[i] == 0) t = i;
      if (t < 0) begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
        for (int i = 0; i < VOICES; i++) if (t < 0 || m_age[i] > m_age[t]) t = i;
`else
        drop = 1'b1;
        return;
`endif
      end
      for (int i = 0; i < VOICES; i++)
        if (i != t && m_act[i] != 0) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
      m_act[t] = 1; m_note[t] = n; m_vel[t] = v; m_age[t] = 0;
      chg[t] = 1'b1;
    end else if (t >= 0) begin
      m_act[t] = 0; m_vel[t] = 0; m_age[t] = 0;
      chg[t] = 1'b1;
    end
  endtask

  task automatic check_pool(input string tag);
    logic [VOICES-1:0]   ea;
    logic [7*VOICES-1:0] en, ev;
    for (int i = 0; i < VOICES; i++) begin
      ea[i] = (m_act[i] != 0);
      en[7*i +: 7] = 7'(m_note[i]);
      ev[7*i +: 7] = 7'(m_vel[i]);
    end
    check({tag, ".active"}, 64'(voice_active), 64'(ea));
    check({tag, ".note"}, 64'(voice_note), 64'(en));
    check({tag, ".vel"}, 64'(voice_velocity), 64'(ev));
  endtask

  task automatic do_reset();
    reset = 1'b1; msg_valid = 1'b0; msg_status = '0; msg_note = '0; msg_velocity = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives one message; checks the busy window and the commit-cycle outputs.
  task automatic send(input string tag, input int st, input int n, input int v);
    int guard;
    logic [VOICES-1:0] echg;
    logic edrop;
    bit is_note;
    guard = 0;
    while (msg_ready !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    if (guard >= 40) check({tag, ".ready_timeout"}, 64'(msg_ready), 64'd1);
    msg_status = 4'(st); msg_note = 7'(n); msg_velocity = 7'(v); msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    model_apply(st, n, v, echg, edrop, is_note);
    if (!is_note) begin
      check({tag, ".ign_ready"}, 64'(msg_ready), 64'd1);
      check({tag, ".ign_chg"}, 64'(voice_change), 64'd0);
      return;
    end
    for (int k = 0; k <= VOICES; k++) begin
      check({tag, ".busy"}, 64'(msg_ready), 64'd0);
      check({tag, ".early_chg"}, 64'({dropped, voice_change}), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, ".ready"}, 64'(msg_ready), 64'd1);
    check({tag, ".chg"}, 64'(voice_change), 64'(echg));
    check({tag, ".drop"}, 64'(dropped), 64'(edrop));
    check_pool(tag);
    @(posedge clk); #1;
    check({tag, ".strobe_clr"}, 64'({dropped, voice_change}), 64'd0);
  endtask

  initial begin
    int st, n, v, r;
    do_reset();
    check("rst.ready", 64'(msg_ready), 64'd1);
    check("rst.chg", 64'({dropped, voice_change}), 64'd0);
    check_pool("rst");

    send("on60", 9, 60, 100);
    check("on60.v0note", 64'(voice_note[6:0]), 64'd60);

    do_reset();
    for (int i = 0; i < VOICES; i++) send("fill", 9, 60 + i, 64 + i);
    check("fill.active", 64'(voice_active), 64'hFF);
    send("full70", 9, 70, 90);
    send("off63", 8, 63, 0);
    check("off63.note_kept", 64'(voice_note[27:21]), 64'd63);

    do_reset();
    send("retrig_a", 9, 60, 100);
    send("retrig_b", 9, 60, 20);
    check("retrig.vel", 64'(voice_velocity[6:0]), 64'd20);

    msg_status = 4'hB; msg_note = 7'd7; msg_velocity = 7'd64; msg_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("cc.ready", 64'(msg_ready), 64'd1);
      check("cc.chg", 64'({dropped, voice_change}), 64'd0);
    end
    msg_valid = 1'b0;
    send("vel0_nomatch", 9, 50, 0);

    send("abort_on", 9, 61, 33);
    do_reset();
    msg_status = 4'h9; msg_note = 7'd55; msg_velocity = 7'd77; msg_valid = 1'b1;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("midrst.ready", 64'(msg_ready), 64'd1);
    check("midrst.chg", 64'({dropped, voice_change}), 64'd0);
    check_pool("midrst");
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("postrst.chg", 64'({dropped, voice_change}), 64'd0);
    end
    check_pool("postrst");

    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      st = (r < 5) ? 9 : (r < 8) ? 8 : $urandom_range(0, 15);
      n = $urandom_range(40, 50);
      v = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127);
      send("rand", st, n, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
